// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port among
// the EXU result producers (0=ALU, 1=MUL, 2=DIV, 3=LSU) with round-robin
// selection, a registered exu_wb_* bus, backpressure and a contention counter.
module wb_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    input  logic [NUM_REQ*5-1:0]     req_rd_addr,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [XLEN-1:0]          exu_wb_data,
    output logic [4:0]               exu_wb_rd_addr,
    output logic                     exu_wb_rd_wr_en,
    output logic [TAG_W-1:0]         exu_wb_tag,
    output logic                     wb_busy,
    output logic [CNT_W-1:0]         contention_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             wr_en_q, wr_en_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [4:0]       rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] x0_req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [XLEN-1:0]    sel_data;
    logic [4:0]         sel_rd;
    logic [TAG_W-1:0]   sel_tag;

    // Split valid requests into port candidates and x0 results that are simply drained
    always_comb begin
        cand   = '0;
        x0_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i]   = req_valid[i] && (req_rd_addr[i*5 +: 5] != 5'd0);
            x0_req[i] = req_valid[i] && (req_rd_addr[i*5 +: 5] == 5'd0);
        end
    end

    // Round-robin pick: first candidate at or above rr_ptr, wrapping around
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        sel_data  = '0;
        sel_rd    = '0;
        sel_tag   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && cand[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                sel_data   = req_data[idx*XLEN +: XLEN];
                sel_rd     = req_rd_addr[idx*5 +: 5];
                sel_tag    = req_tag[idx*TAG_W +: TAG_W];
            end
        end
    end

    // Ready depends only on the current inputs and rr_ptr, never on the output register
    assign req_ready = x0_req | grant;
    assign wb_busy   = |(cand & ~grant);

    // Next-state: load the winner's slice, advance the pointer past it, count contention
    always_comb begin
        wr_en_d  = grant_vld;
        data_d   = data_q;
        rd_d     = rd_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (grant_vld) begin
            data_d   = sel_data;
            rd_d     = sel_rd;
            tag_d    = sel_tag;
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (wb_busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops any in-flight writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            rd_q     <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign exu_wb_data     = data_q;
    assign exu_wb_rd_addr  = rd_q;
    assign exu_wb_rd_wr_en = wr_en_q;
    assign exu_wb_tag      = tag_q;
    assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a scoreboard of expected writebacks.
module tb_wb_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [19:0]  req_rd_addr;
    logic [31:0]  req_tag;

    logic [3:0]   req_ready,  req_ready_s;
    logic [31:0]  wb_data,    wb_data_s;
    logic [4:0]   wb_rd,      wb_rd_s;
    logic         wb_en,      wb_en_s;
    logic [7:0]   wb_tag,     wb_tag_s;
    logic         wb_busy,    wb_busy_s;
    logic [31:0]  cnt;
    logic [3:0]   cnt_s;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_rd_addr(req_rd_addr), .req_tag(req_tag), .req_ready(req_ready),
        .exu_wb_data(wb_data), .exu_wb_rd_addr(wb_rd), .exu_wb_rd_wr_en(wb_en),
        .exu_wb_tag(wb_tag), .wb_busy(wb_busy), .contention_cnt(cnt)
    );

    wb_port_arbiter #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_rd_addr(req_rd_addr), .req_tag(req_tag), .req_ready(req_ready_s),
        .exu_wb_data(wb_data_s), .exu_wb_rd_addr(wb_rd_s), .exu_wb_rd_wr_en(wb_en_s),
        .exu_wb_tag(wb_tag_s), .wb_busy(wb_busy_s), .contention_cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic [4:0]  r;
        logic [7:0]  t;
    } wb_t;

    wb_t sbq[$];
    wb_t last_exp;
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] r, input logic [7:0] t);
        req_data[i*32 +: 32] = d;
        req_rd_addr[i*5 +: 5] = r;
        req_tag[i*8 +: 8]     = t;
    endtask

    // One clock: check combinational outputs, queue the expected write, then check the register
    task automatic cycle(input logic [3:0] exp_ready, input logic exp_busy, input int g, input string name);
        wb_t e;
        wb_t o;
        #1;
        chk({name, "_ready"}, 64'(req_ready), 64'(exp_ready));
        chk({name, "_busy"}, 64'(wb_busy), 64'(exp_busy));
        if (g >= 0) begin
            e.en = 1'b1;
            e.d  = req_data[g*32 +: 32];
            e.r  = req_rd_addr[g*5 +: 5];
            e.t  = req_tag[g*8 +: 8];
        end else begin
            e    = last_exp;
            e.en = 1'b0;
        end
        last_exp = e;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o = sbq.pop_front();
        chk({name, "_wr_en"}, 64'(wb_en), 64'(o.en));
        chk({name, "_data"}, 64'(wb_data), 64'(o.d));
        chk({name, "_rd"}, 64'(wb_rd), 64'(o.r));
        chk({name, "_tag"}, 64'(wb_tag), 64'(o.t));
        chk({name, "_s_wr_en"}, 64'(wb_en_s), 64'(o.en));
    endtask

    task automatic do_reset(input string name);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk({name, "_wr_en"}, 64'(wb_en), 64'd0);
        chk({name, "_data"}, 64'(wb_data), 64'd0);
        chk({name, "_rd"}, 64'(wb_rd), 64'd0);
        chk({name, "_tag"}, 64'(wb_tag), 64'd0);
        chk({name, "_cnt"}, 64'(cnt), 64'd0);
        chk({name, "_cnt_s"}, 64'(cnt_s), 64'd0);
        last_exp = '{en: 1'b0, d: 32'd0, r: 5'd0, t: 8'd0};
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_rd_addr = '0;
        req_tag     = '0;
        last_exp    = '{en: 1'b0, d: 32'd0, r: 5'd0, t: 8'd0};

        // Reset then idle
        do_reset("rst0");
        cycle(4'b0000, 1'b0, -1, "idle");

        // Single ALU result, then port goes idle and data holds
        set_req(0, 32'hDEADBEEF, 5'd5, 8'h12);
        req_valid = 4'b0001;
        cycle(4'b0001, 1'b0, 0, "alu");
        req_valid = 4'b0000;
        cycle(4'b0000, 1'b0, -1, "alu_after");

        // All four continuously valid from reset: strict rotation
        do_reset("rst1");
        for (int i = 0; i < 4; i++) set_req(i, 32'hA000_0000 + i, 5'(i + 1), 8'(8'h40 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) cycle(4'b0001 << (k % 4), 1'b1, k % 4, $sformatf("rr%0d", k));
        chk("rr_cnt", 64'(cnt), 64'd8);
        chk("rr_cnt_s", 64'(cnt_s), 64'd8);

        // x0 bypass: MUL to x0 and ALU to x7 together, pointer must only move to 1
        req_valid = 4'b0000;
        set_req(0, 32'h0000_0777, 5'd7, 8'h70);
        set_req(1, 32'hBAD0_0000, 5'd0, 8'h71);
        req_valid = 4'b0011;
        cycle(4'b0011, 1'b0, 0, "x0");
        for (int i = 0; i < 4; i++) set_req(i, 32'hB000_0000 + i, 5'(i + 10), 8'(8'h50 + i));
        req_valid = 4'b1111;
        cycle(4'b0010, 1'b1, 1, "x0_ptr");
        chk("x0_cnt", 64'(cnt), 64'd9);

        // Hold under backpressure: ALU wins first, DIV keeps 0x55 and wins next
        do_reset("rst2");
        set_req(0, 32'h0000_0011, 5'd8, 8'h21);
        set_req(2, 32'h0000_0055, 5'd9, 8'h33);
        req_valid = 4'b0101;
        cycle(4'b0001, 1'b1, 0, "hold_alu");
        req_valid = 4'b0100;
        cycle(4'b0100, 1'b0, 2, "hold_div");
        chk("hold_cnt", 64'(cnt), 64'd1);

        // Reset while a write is on the bus; pointer must restart at 0
        for (int i = 0; i < 4; i++) set_req(i, 32'hC000_0000 + i, 5'(i + 20), 8'(8'h60 + i));
        req_valid = 4'b1111;
        cycle(4'b1000, 1'b1, 3, "pre_rst");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_wr_en", 64'(wb_en), 64'd0);
        chk("midrst_cnt", 64'(cnt), 64'd0);
        last_exp = '{en: 1'b0, d: 32'd0, r: 5'd0, t: 8'd0};
        cycle(4'b0001, 1'b1, 0, "post_rst");

        // Saturation of the narrow counter over 20 more contended cycles
        for (int k = 1; k <= 20; k++) cycle(4'b0001 << (k % 4), 1'b1, k % 4, $sformatf("sat%0d", k));
        chk("sat_cnt_s", 64'(cnt_s), 64'd15);
        chk("sat_cnt", 64'(cnt), 64'd21);
        req_valid = 4'b0000;
        cycle(4'b0000, 1'b0, -1, "end_idle");
        chk("sat_hold_s", 64'(cnt_s), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port among the EXU result producers: ALU, pipelined MUL, blocking DIV and LSU. It accepts results over per-requester valid/ready handshakes and grants one per cycle using round-robin. It drives the registered exu_wb_* bus into idu1, which uses it for the reg_file write and for WB forwarding. It also reports backpressure so EXU units can hold results, and keeps a saturating contention counter.

Parameters:
XLEN, 32, data width of a writeback result
NUM_REQ, 4, number of requesters (index 0=ALU, 1=MUL, 2=DIV, 3=LSU)
TAG_W, 8, width of instr_tag carried with each result
CNT_W, 32, width of the contention counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  requester i has a result pending
req_data  input  NUM_REQ*XLEN  result of requester i, slice [i*XLEN +: XLEN]
req_rd_addr  input  NUM_REQ*5  destination register of requester i
req_tag  input  NUM_REQ*TAG_W  instr_tag of requester i
req_ready  output  NUM_REQ  result of requester i accepted this cycle
exu_wb_data  output  XLEN  registered writeback data
exu_wb_rd_addr  output  5  registered writeback register
exu_wb_rd_wr_en  output  1  registered writeback enable
exu_wb_tag  output  TAG_W  tag of the instruction being written back
wb_busy  output  1  at least one valid nonzero-rd request is not granted this cycle
contention_cnt  output  CNT_W  saturating count of cycles with wb_busy=1

Behaviour:
- Single clock domain. Reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - exu_wb_rd_wr_en=0, exu_wb_data=0, exu_wb_rd_addr=0, exu_wb_tag=0.
  - Round-robin pointer rr_ptr=0.
  - contention_cnt=0.
- Reset asserted mid-operation discards all in-flight grants. Requesters must re-present their results after reset.
- Handshake rules:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Once req_valid[i] is high, the requester holds valid, data, rd_addr and tag stable until ready.
  - req_ready is combinational from the current inputs and rr_ptr. It has no dependence on the output register, so there are no bubbles.
- x0 requests: req_valid[i] with req_rd_addr[i]==0 gets req_ready[i]=1 in the same cycle. It is not a port candidate, produces no write, and does not move rr_ptr.
- Candidates are requesters with valid=1 and rd_addr!=0.
- Grant selection:
  - Grant the first candidate found scanning from index rr_ptr upward, wrapping modulo NUM_REQ.
  - Exactly one grant per cycle, or none if there are no candidates.
- Next-state registers on a grant g (1-cycle latency from accept to write):
  - exu_wb_rd_wr_en<=1.
  - exu_wb_data, exu_wb_rd_addr, exu_wb_tag <= slice g.
  - rr_ptr<=(g+1) mod NUM_REQ.
- Next-state with no grant: exu_wb_rd_wr_en<=0; data, addr and tag hold their previous values; rr_ptr holds.
- wb_busy=1 when candidate count minus granted count is ≥1, i.e. some candidate lost arbitration. It is combinational.
- contention_cnt increments by 1 each cycle wb_busy=1 and saturates at all-ones (no wrap).
- Fairness: with all NUM_REQ candidates continuously valid, each requester is granted exactly once every NUM_REQ cycles.
- Same-register ordering across requesters is not enforced here. It is the issue stage's responsibility via its stall logic.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst_n=0 for 2 cycles, then release with req_valid=0.
  - Required: exu_wb_rd_wr_en=0, all outputs 0, contention_cnt=0.
- Single ALU result:
  - Stimulus: req_valid=4'b0001, rd=5, data=0xDEADBEEF, tag=0x12 for 1 cycle.
  - Required: req_ready[0]=1 that cycle. Next cycle wr_en=1, rd_addr=5, data=0xDEADBEEF, tag=0x12. Following cycle wr_en=0.
- All four continuously valid (rd=1..4) for 8 cycles from reset:
  - Required grant order: 0,1,2,3,0,1,2,3.
  - wb_busy=1 every cycle; contention_cnt=8.
- x0 bypass:
  - Stimulus: MUL valid with rd=0, and ALU valid with rd=7, in the same cycle.
  - Required: both ready=1; the write goes to rd=7 only; rr_ptr=1; wb_busy=0.
- Hold under backpressure:
  - Stimulus: ALU and DIV valid with rr_ptr=0; DIV holds data=0x55 stable.
  - Required: ALU granted first. DIV is granted the next cycle with data 0x55 written. contention_cnt +1.
- Reset mid-stream and saturation:
  - Stimulus: pulse rst_n=0 while wr_en=1.
  - Required: next cycle wr_en=0 and rr_ptr=0.
  - With CNT_W=4 and 20 contended cycles, contention_cnt stays at 15.
